// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: single-clock FIFO for any DEPTH >= 2, with fill count, programmable thresholds and standard/FWFT read modes.
// Optional overflow/underflow outputs are enabled by defining FIFO_SYNC_FLEX_ERR_EN.
module fifo_sync_flex #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int PROG_FULL  = DEPTH/2,
  parameter int PROG_EMPTY = 1,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       prog_full,
  output logic [WIDTH-1:0]           dout,
  input  logic                       rd_en,
  output logic                       empty,
  output logic                       prog_empty,
  output logic                       valid,
`ifdef FIFO_SYNC_FLEX_ERR_EN
  output logic                       overflow,
  output logic                       underflow,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_PF    = CW'(PROG_FULL);
  localparam logic [CW-1:0] C_PE    = CW'(PROG_EMPTY);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_LAST  = PW'(DEPTH-1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("fifo_sync_flex: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_sync_flex: DEPTH must be >= 2");
    end
    if (PROG_FULL < 1 || PROG_FULL > DEPTH) begin : g_bad_pf
      $error("fifo_sync_flex: PROG_FULL out of range 1..DEPTH");
    end
    if (PROG_EMPTY < 0 || PROG_EMPTY > DEPTH-1) begin : g_bad_pe
      $error("fifo_sync_flex: PROG_EMPTY out of range 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("fifo_sync_flex: FWFT must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_mem_rd;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + P_ONE;
  endfunction

  assign full       = (r_count == C_DEPTH);
  assign prog_full  = (r_count >= C_PF);
  assign prog_empty = (r_count <= C_PE);
  assign count      = r_count;
  assign dout       = r_dout;
  assign valid      = r_valid;
  assign w_wr_acc   = wr_en & ~full;
  assign w_rd_acc   = rd_en & ~empty;

  generate
    if (FWFT == 1) begin : g_fwft
      // r_valid marks an occupied output register; the RAM holds count minus that word.
      // The RAM can only be full while the output register is empty, so a
      // same-address read/write never coincides with a head-word load.
      logic [CW-1:0] w_mem_cnt;
      assign w_mem_cnt = r_count - CW'(r_valid);
      assign empty     = ~r_valid;
      assign w_mem_rd  = (w_mem_cnt != '0) & (~r_valid | w_rd_acc);
    end else begin : g_std
      assign empty    = (r_count == '0);
      assign w_mem_rd = w_rd_acc;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_mem_rd) r_rd_ptr <= f_next(r_rd_ptr);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + C_ONE;
      else if (!w_wr_acc && w_rd_acc) r_count <= r_count - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din;
  end

  // Registered RAM read port doubles as the output/head register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_mem_rd) r_dout <= r_mem[r_rd_ptr];
      if (FWFT == 1) begin
        if (w_mem_rd)      r_valid <= 1'b1;
        else if (w_rd_acc) r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_acc;
      end
    end
  end

`ifdef FIFO_SYNC_FLEX_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= wr_en & full;
      r_unf <= rd_en & empty;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`endif

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Directed self-checking bench for fifo_sync_flex: DEPTH=4 standard, DEPTH=5 standard and DEPTH=4 FWFT instances.
module tb_fifo_sync_flex;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] a_din, a_dout;
  logic       a_wr, a_rd, a_full, a_pf, a_empty, a_pe, a_valid;
  logic [2:0] a_count;
  logic [7:0] b_din, b_dout;
  logic       b_wr, b_rd, b_full, b_pf, b_empty, b_pe, b_valid;
  logic [2:0] b_count;
  logic [7:0] c_din, c_dout;
  logic       c_wr, c_rd, c_full, c_pf, c_empty, c_pe, c_valid;
  logic [2:0] c_count;
`ifdef FIFO_SYNC_FLEX_ERR_EN
  logic a_ovf, a_unf, b_ovf, b_unf, c_ovf, c_unf;
`endif

  fifo_sync_flex #(.WIDTH(8), .DEPTH(4), .PROG_FULL(3), .PROG_EMPTY(1), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .wr_en(a_wr), .full(a_full), .prog_full(a_pf),
    .dout(a_dout), .rd_en(a_rd), .empty(a_empty), .prog_empty(a_pe), .valid(a_valid),
`ifdef FIFO_SYNC_FLEX_ERR_EN
    .overflow(a_ovf), .underflow(a_unf),
`endif
    .count(a_count));

  fifo_sync_flex #(.WIDTH(8), .DEPTH(5), .PROG_FULL(5), .PROG_EMPTY(1), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .wr_en(b_wr), .full(b_full), .prog_full(b_pf),
    .dout(b_dout), .rd_en(b_rd), .empty(b_empty), .prog_empty(b_pe), .valid(b_valid),
`ifdef FIFO_SYNC_FLEX_ERR_EN
    .overflow(b_ovf), .underflow(b_unf),
`endif
    .count(b_count));

  fifo_sync_flex #(.WIDTH(8), .DEPTH(4), .PROG_FULL(3), .PROG_EMPTY(1), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .din(c_din), .wr_en(c_wr), .full(c_full), .prog_full(c_pf),
    .dout(c_dout), .rd_en(c_rd), .empty(c_empty), .prog_empty(c_pe), .valid(c_valid),
`ifdef FIFO_SYNC_FLEX_ERR_EN
    .overflow(c_ovf), .underflow(c_unf),
`endif
    .count(c_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    #3;
    got = {a_count, a_full, a_pf, a_pe, a_empty, a_valid};
    exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_a_flags got %b exp %b", got, exp); end
    checks++;
    if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_a_dout got %h exp 00", a_dout); end
    got = {b_count, b_full, b_pf, b_pe, b_empty, b_valid};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_b_flags got %b exp %b", got, exp); end
    got = {c_count, c_full, c_pf, c_pe, c_empty, c_valid};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_c_flags got %b exp %b", got, exp); end
`ifdef FIFO_SYNC_FLEX_ERR_EN
    checks++;
    if ({a_ovf, a_unf, b_ovf, b_unf, c_ovf, c_unf} !== 6'b0) begin
      errors++; $display("FAIL reset_err got %b exp 000000", {a_ovf, a_unf, b_ovf, b_unf, c_ovf, c_unf});
    end
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    checks++;
    if (a_count !== 3'd0 || a_empty !== 1'b1) begin
      errors++; $display("FAIL reset_release got count %0d empty %b exp 0 1", a_count, a_empty);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] wd [4];
    logic [6:0] got7, exp7;
    logic [12:0] got13, exp13;
    wd = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      a_din = wd[i]; a_wr = 1'b1;
      tick();
      got7 = {a_count, a_pf, a_pe, a_empty, a_full};
      exp7 = {3'(i+1), (i >= 2), (i == 0), 1'b0, (i == 3)};
      checks++;
      if (got7 !== exp7) begin errors++; $display("FAIL fill_%0d got %b exp %b", i, got7, exp7); end
    end
    a_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_rd = 1'b1;
      tick();
      got13 = {a_valid, a_dout, a_count, a_empty};
      exp13 = {1'b1, wd[i], 3'(3-i), (i == 3)};
      checks++;
      if (got13 !== exp13) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, got13, exp13); end
    end
    a_rd = 1'b0;
    tick();
    checks++;
    if (a_valid !== 1'b0 || a_dout !== 8'h44) begin
      errors++; $display("FAIL drain_hold got valid %b dout %h exp 0 44", a_valid, a_dout);
    end
  endtask

  task automatic test_full_simul();
    logic [12:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      a_din = 8'h51 + 8'(i); a_wr = 1'b1;
      tick();
    end
    a_din = 8'h99; a_rd = 1'b1;
    tick();
    got = {a_count, a_valid, a_dout, a_full};
    exp = {3'd3, 1'b1, 8'h51, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL full_wr_rd got %h exp %h", got, exp); end
    a_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_dout !== 8'h52 + 8'(i)) begin
        errors++; $display("FAIL full_drain_%0d got %h exp %h", i, a_dout, 8'h52 + 8'(i));
      end
    end
    a_din = 8'h77; a_wr = 1'b1; a_rd = 1'b1;
    tick();
    got = {a_count, a_valid, a_dout, a_empty};
    exp = {3'd1, 1'b0, 8'h54, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL empty_wr_rd got %h exp %h", got, exp); end
    a_wr = 1'b0;
    tick();
    got = {a_count, a_valid, a_dout, a_empty};
    exp = {3'd0, 1'b1, 8'h77, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL empty_wr_rd_read got %h exp %h", got, exp); end
    a_rd = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int exp_rd = 1;
    for (int i = 1; i <= 3; i++) begin
      b_din = 8'(i); b_wr = 1'b1;
      tick();
    end
    b_rd = 1'b1;
    for (int i = 4; i <= 15; i++) begin
      b_din = 8'(i);
      tick();
      checks++;
      if (b_valid !== 1'b1 || b_dout !== 8'(exp_rd) || b_count !== 3'd3) begin
        errors++;
        $display("FAIL wrap_%0d got valid %b dout %h count %0d exp 1 %h 3", i, b_valid, b_dout, b_count, 8'(exp_rd));
      end
      exp_rd++;
    end
    b_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b_dout !== 8'(exp_rd) || b_count !== 3'(2-i)) begin
        errors++; $display("FAIL wrap_tail_%0d got %h/%0d exp %h/%0d", i, b_dout, b_count, 8'(exp_rd), 2-i);
      end
      exp_rd++;
    end
    b_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_din = 8'h20 + 8'(i); b_wr = 1'b1;
      tick();
    end
    b_wr = 1'b0;
    checks++;
    if ({b_count, b_full, b_pf, b_pe} !== {3'd5, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wrap_full got %b exp 101110", {b_count, b_full, b_pf, b_pe});
    end
    b_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b_dout !== 8'h20 + 8'(i)) begin
        errors++; $display("FAIL wrap_full_drain_%0d got %h exp %h", i, b_dout, 8'h20 + 8'(i));
      end
    end
    b_rd = 1'b0;
    checks++;
    if (b_empty !== 1'b1 || b_count !== 3'd0) begin
      errors++; $display("FAIL wrap_empty got %b/%0d exp 1/0", b_empty, b_count);
    end
  endtask

  task automatic test_fwft();
    logic [7:0] q[$];
    logic [11:0] got, exp;
    c_din = 8'hA5; c_wr = 1'b1;
    tick();
    c_wr = 1'b0;
    checks++;
    if (c_empty !== 1'b1 || c_count !== 3'd1) begin
      errors++; $display("FAIL fwft_lat_n got empty %b count %0d exp 1 1", c_empty, c_count);
    end
    tick();
    got = {c_empty, c_valid, c_dout, 2'(c_count)};
    exp = {1'b0, 1'b1, 8'hA5, 2'd1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL fwft_lat_n1 got %h exp %h", got, exp); end
    c_din = 8'hB0; c_wr = 1'b1;
    tick();
    q = '{8'hA5, 8'hB0};
    c_rd = 1'b1;
    for (int k = 0; k < 6; k++) begin
      c_din = 8'hC0 + 8'(k);
      tick();
      void'(q.pop_front());
      q.push_back(8'hC0 + 8'(k));
      checks++;
      if (c_empty !== 1'b0 || c_dout !== q[0] || c_count !== 3'd2) begin
        errors++; $display("FAIL fwft_stream_%0d got %b %h %0d exp 0 %h 2", k, c_empty, c_dout, c_count, q[0]);
      end
    end
    c_wr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      void'(q.pop_front());
      if (q.size() > 0) begin
        checks++;
        if (c_empty !== 1'b0 || c_dout !== q[0] || c_count !== 3'(q.size())) begin
          errors++; $display("FAIL fwft_drain_%0d got %b %h %0d exp 0 %h %0d", k, c_empty, c_dout, c_count, q[0], q.size());
        end
      end else begin
        checks++;
        if (c_empty !== 1'b1 || c_valid !== 1'b0 || c_count !== 3'd0) begin
          errors++; $display("FAIL fwft_drain_end got %b %b %0d exp 1 0 0", c_empty, c_valid, c_count);
        end
      end
    end
    c_rd = 1'b0;
  endtask

  task automatic test_fwft_full();
    for (int i = 0; i < 4; i++) begin
      c_din = 8'hD0 + 8'(i); c_wr = 1'b1;
      tick();
    end
    c_din = 8'hEE;
    tick();
    checks++;
    if ({c_count, c_full, c_pf, c_pe, c_empty} !== {3'd4, 1'b1, 1'b1, 1'b0, 1'b0} || c_dout !== 8'hD0) begin
      errors++; $display("FAIL fwft_full got %b dout %h exp 1001100 d0", {c_count, c_full, c_pf, c_pe, c_empty}, c_dout);
    end
    c_rd = 1'b1;
    tick();
    c_wr = 1'b0;
    checks++;
    if (c_count !== 3'd3 || c_dout !== 8'hD1) begin
      errors++; $display("FAIL fwft_full_wr_rd got %0d %h exp 3 d1", c_count, c_dout);
    end
    for (int i = 2; i < 4; i++) begin
      tick();
      checks++;
      if (c_dout !== 8'hD0 + 8'(i) || c_empty !== 1'b0) begin
        errors++; $display("FAIL fwft_full_drain_%0d got %h exp %h", i, c_dout, 8'hD0 + 8'(i));
      end
    end
    tick();
    c_rd = 1'b0;
    checks++;
    if (c_empty !== 1'b1 || c_count !== 3'd0) begin
      errors++; $display("FAIL fwft_full_end got %b/%0d exp 1/0", c_empty, c_count);
    end
  endtask

`ifdef FIFO_SYNC_FLEX_ERR_EN
  task automatic test_err();
    for (int i = 0; i < 4; i++) begin
      a_din = 8'h60 + 8'(i); a_wr = 1'b1;
      tick();
    end
    checks++;
    if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", a_ovf); end
    tick();
    a_wr = 1'b0;
    checks++;
    if (a_ovf !== 1'b1 || a_count !== 3'd4) begin
      errors++; $display("FAIL ovf_pulse got %b/%0d exp 1/4", a_ovf, a_count);
    end
    tick();
    checks++;
    if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", a_ovf); end
    a_rd = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (a_unf !== 1'b0) begin errors++; $display("FAIL unf_early got %b exp 0", a_unf); end
    tick();
    a_rd = 1'b0;
    checks++;
    if (a_unf !== 1'b1 || a_count !== 3'd0) begin
      errors++; $display("FAIL unf_pulse got %b/%0d exp 1/0", a_unf, a_count);
    end
    tick();
    checks++;
    if (a_unf !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", a_unf); end
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      c_din = 8'h30 + 8'(i); c_wr = 1'b1;
      a_din = 8'h40 + 8'(i); a_wr = 1'b1; a_rd = (i == 2);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({c_count, c_empty, c_valid, c_dout} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rst_mid_c got %0d %b %b %h exp 0 1 0 00", c_count, c_empty, c_valid, c_dout);
    end
    checks++;
    if ({a_count, a_empty, a_valid, a_dout} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rst_mid_a got %0d %b %b %h exp 0 1 0 00", a_count, a_empty, a_valid, a_dout);
    end
    c_wr = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    c_din = 8'h3C; c_wr = 1'b1;
    tick();
    c_wr = 1'b0;
    tick();
    checks++;
    if (c_empty !== 1'b0 || c_dout !== 8'h3C || c_count !== 3'd1) begin
      errors++; $display("FAIL rst_mid_after got %b %h %0d exp 0 3c 1", c_empty, c_dout, c_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    a_din = '0; a_wr = 1'b0; a_rd = 1'b0;
    b_din = '0; b_wr = 1'b0; b_rd = 1'b0;
    c_din = '0; c_wr = 1'b0; c_rd = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_wrap();
    test_fwft();
    test_fwft_full();
`ifdef FIFO_SYNC_FLEX_ERR_EN
    test_err();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
